// File: rtl/sound_sequencer_if.sv
// ============================================================================
// Module      : sound_sequencer_if
// Description : Game-event inputs and tone-command outputs of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sound_sequencer_if;
    logic       ev_ping_l;
    logic       ev_ping_r;
    logic       ev_pong;
    logic       ev_goal_l;
    logic       ev_goal_r;
    logic [1:0] sound;
    logic [1:0] channel;
    logic       busy;

    modport master (
        output ev_ping_l, ev_ping_r, ev_pong, ev_goal_l, ev_goal_r,
        input  sound, channel, busy
    );

    modport slave (
        input  ev_ping_l, ev_ping_r, ev_pong, ev_goal_l, ev_goal_r,
        output sound, channel, busy
    );
endinterface

`default_nettype wire

// File: rtl/sound_sequencer.sv
// ============================================================================
// Module      : sound_sequencer
// Description : Turns one-cycle game events into timed, prioritised tone
//               commands (ping, pong, repeated goal beeps) for the sound card.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sound_sequencer #(
    parameter int CNT_W      = 24,
    parameter int PING_TICKS = 2_500_000,
    parameter int PONG_TICKS = 2_500_000,
    parameter int GOAL_TICKS = 5_000_000,
    parameter int GAP_TICKS  = 2_500_000,
    parameter int GOAL_REPS  = 3
) (
    input  wire               clk,
    input  wire               reset,
    sound_sequencer_if.slave  bus
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_PING     = 3'd1;
    localparam logic [2:0] c_PONG     = 3'd2;
    localparam logic [2:0] c_GOAL_ON  = 3'd3;
    localparam logic [2:0] c_GOAL_GAP = 3'd4;

    localparam logic [1:0] c_SND_NONE = 2'd0;
    localparam logic [1:0] c_SND_PING = 2'd1;
    localparam logic [1:0] c_SND_PONG = 2'd2;
    localparam logic [1:0] c_SND_GOAL = 2'd3;
    localparam logic [1:0] c_CH_NONE  = 2'd0;
    localparam logic [1:0] c_CH_BOTH  = 2'd3;

    localparam logic [CNT_W-1:0] c_PING_LD = CNT_W'(PING_TICKS - 1);
    localparam logic [CNT_W-1:0] c_PONG_LD = CNT_W'(PONG_TICKS - 1);
    localparam logic [CNT_W-1:0] c_GOAL_LD = CNT_W'(GOAL_TICKS - 1);
    localparam logic [CNT_W-1:0] c_GAP_LD  = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [3:0]       c_REP_LD  = 4'(GOAL_REPS - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_rep;
    logic [1:0]       r_goal_ch;
    logic [1:0]       r_sound;
    logic [1:0]       r_channel;
    logic             r_busy;

    logic       w_goal;
    logic       w_ping;
    logic       w_in_goal;
    logic       w_take_ping;
    logic       w_take_pong;
    logic       w_cnt_zero;
    logic [1:0] w_goal_ch;
    logic [1:0] w_ping_ch;

    assign w_goal      = bus.ev_goal_l | bus.ev_goal_r;
    assign w_ping      = bus.ev_ping_l | bus.ev_ping_r;
    assign w_goal_ch   = {bus.ev_goal_l, bus.ev_goal_r};
    assign w_ping_ch   = {bus.ev_ping_l, bus.ev_ping_r};
    assign w_in_goal   = (r_state == c_GOAL_ON) || (r_state == c_GOAL_GAP);
    // Lower-priority events are only accepted when nothing above them plays.
    assign w_take_ping = w_ping & ~w_in_goal;
    assign w_take_pong = bus.ev_pong & ((r_state == c_IDLE) || (r_state == c_PONG));
    assign w_cnt_zero  = (r_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_rep     <= '0;
            r_goal_ch <= c_CH_NONE;
            r_sound   <= c_SND_NONE;
            r_channel <= c_CH_NONE;
            r_busy    <= 1'b0;
        end else if (w_goal) begin
            r_state   <= c_GOAL_ON;
            r_cnt     <= c_GOAL_LD;
            r_rep     <= c_REP_LD;
            r_goal_ch <= w_goal_ch;
            r_sound   <= c_SND_GOAL;
            r_channel <= w_goal_ch;
            r_busy    <= 1'b1;
        end else if (w_take_ping) begin
            r_state   <= c_PING;
            r_cnt     <= c_PING_LD;
            r_sound   <= c_SND_PING;
            r_channel <= w_ping_ch;
            r_busy    <= 1'b1;
        end else if (w_take_pong) begin
            r_state   <= c_PONG;
            r_cnt     <= c_PONG_LD;
            r_sound   <= c_SND_PONG;
            r_channel <= c_CH_BOTH;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                end
                c_PING, c_PONG: begin
                    if (w_cnt_zero) begin
                        r_state   <= c_IDLE;
                        r_sound   <= c_SND_NONE;
                        r_channel <= c_CH_NONE;
                        r_busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                c_GOAL_ON: begin
                    if (w_cnt_zero) begin
                        if (r_rep != 4'd0) begin
                            r_state   <= c_GOAL_GAP;
                            r_cnt     <= c_GAP_LD;
                            r_channel <= c_CH_NONE;
                        end else begin
                            r_state   <= c_IDLE;
                            r_sound   <= c_SND_NONE;
                            r_channel <= c_CH_NONE;
                            r_busy    <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                c_GOAL_GAP: begin
                    // Sound code stays at goal during the gap; only the channel mutes.
                    if (w_cnt_zero) begin
                        r_state   <= c_GOAL_ON;
                        r_cnt     <= c_GOAL_LD;
                        r_rep     <= r_rep - 4'd1;
                        r_channel <= r_goal_ch;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: begin
                    r_state   <= c_IDLE;
                    r_sound   <= c_SND_NONE;
                    r_channel <= c_CH_NONE;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sound   = r_sound;
    assign bus.channel = r_channel;
    assign bus.busy    = r_busy;

endmodule

`default_nettype wire
